y_poly_writer: RTL and testbench
================================

Y_POLY_WRITER -- requirements
Module: y_poly_writer

Interface
REQ-001 Parameter SAMPLE_W, default 23, coefficient width in bits.
REQ-002 Parameter BUS_W, default 4, coefficients per input beat and per memory word.
REQ-003 Parameter ADDR_W, default 9, memory word-address width.
REQ-004 Port clk, input, 1, single clock; one clock; all logic on rising edge.
REQ-005 Port rst, input, 1, reset; reset is synchronous and active-high.
REQ-006 Port sec_lvl, input, 3, security level (2, 3 or 5), sampled on accepted start.
REQ-007 Port start, input, 1, one-cycle request to write one full y vector.
REQ-008 Port base_addr, input, ADDR_W, first word address, sampled on accepted start.
REQ-009 Port valid_i, input, 1, upstream sampler beat valid.
REQ-010 Port ready_i, output, 1, block accepts a beat this cycle.
REQ-011 Port samples, input, SAMPLE_W*BUS_W, packed coefficients, lane 0 in LSBs.
REQ-012 Port mem_we, output, 1, memory write enable.
REQ-013 Port mem_addr, output, ADDR_W, memory write address.
REQ-014 Port mem_wdata, output, SAMPLE_W*BUS_W, memory write data.
REQ-015 Port poly_idx, output, 3, index of polynomial currently being filled.
REQ-016 Port flush_o, output, 1, one-cycle pulse requesting upstream sampler/hash clear and re-seed.
REQ-017 Port poly_done, output, 1, one-cycle pulse per completed polynomial.
REQ-018 Port done, output, 1, one-cycle pulse when all L polynomials are written.
REQ-019 Port busy, output, 1, high in every state except IDLE.

Function
REQ-020 L SHALL be 4 for sec_lvl 2, 7 for sec_lvl 5, and 5 for sec_lvl 3 and all reserved codes.
REQ-021 States SHALL be IDLE, WRITE, FLUSH and DONE.
REQ-022 IDLE: start loads L, base_addr, poly_idx=0 and beat_cnt=0, then goes to WRITE; ready_i=0.
REQ-023 start SHALL be ignored outside IDLE.
REQ-024 WRITE: ready_i=1; a beat is accepted when valid_i && ready_i.
REQ-025 Each accepted beat SHALL register mem_we=1, mem_wdata=samples and mem_addr=(base+poly_idx*64+beat_cnt) mod 2^ADDR_W, driven on the next cycle; latency 1.
REQ-026 beat_cnt (6 bits) SHALL increment per accepted beat; the beat accepted at beat_cnt=63 moves the FSM to FLUSH (256 coefficients per polynomial).
REQ-027 FLUSH (exactly 1 cycle): ready_i=0, flush_o=1, poly_done=1, beat_cnt clears; poly_idx increments unless it equals L-1.
REQ-028 From FLUSH: go to DONE if the finished poly_idx was L-1, else go to WRITE.
REQ-029 DONE (1 cycle): done=1, then go to IDLE; poly_idx holds its final value until the next start.
REQ-030 mem_we SHALL be 0 in any cycle that is not preceded by an accepted beat.
REQ-031 valid_i while ready_i=0 SHALL have no effect; samples need not be held stable by the block.
REQ-032 Coefficients SHALL pass through unmodified; no arithmetic on data.

Reset
REQ-033 rst SHALL force state IDLE and set ready_i, mem_we, mem_addr, mem_wdata, poly_idx, flush_o, poly_done, done, busy and all counters to 0.
REQ-034 rst mid-operation SHALL abort with no done or poly_done pulse; rst overrides start in the same cycle.
REQ-035 A write registered in the cycle rst is asserted SHALL be dropped (mem_we=0 on the next cycle).

Structure
REQ-036 DILITHIUM_Q, SAMPLE_W, BUS_W, the coefficient count N=256 and the per-level L table SHALL live in a shared dilithium params package.
REQ-037 The block SHALL be flat with no sub-module; an L-lookup function from the package is allowed.

Verification
REQ-038 Test 1: sec_lvl=2, base=0, continuous valid -> 256 writes at addresses 0..255, poly_done at writes 64/128/192/256, one done, poly_idx ending at 3.
REQ-039 Test 2: sec_lvl=5, base=0x1C0 -> 448 writes with addresses wrapping 0x1FF->0x000, L=7 poly_done pulses.
REQ-040 Test 3: random valid_i gaps (50%) -> mem_wdata sequence matches input beats in order; no writes during FLUSH.
REQ-041 Test 4: rst asserted after 100 beats of sec_lvl=3 -> all outputs 0 next cycle, no done; a new start then writes from base.
REQ-042 Test 5: start pulsed during WRITE and sec_lvl changed mid-run -> ignored; L stays as sampled.
REQ-043 Test 6: sec_lvl=7 (reserved) -> behaves as L=5 (320 writes).

Source files
------------

// File: rtl/y_poly_writer_pkg.sv
// Shared Dilithium parameters: modulus, coefficient geometry and the per-level L table.
// Also holds the writer FSM state encoding so the top and any future helpers agree on it.
package y_poly_writer_pkg;

   localparam int unsigned DILITHIUM_Q    = 8380417;
   localparam int unsigned SAMPLE_W       = 23;
   localparam int unsigned BUS_W          = 4;
   localparam int unsigned N              = 256;
   localparam int unsigned BEATS_PER_POLY = N / BUS_W;

   localparam int unsigned L_LVL2 = 4;
   localparam int unsigned L_LVL3 = 5;
   localparam int unsigned L_LVL5 = 7;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // Reserved security levels fall back to the level-3 vector length.
   function automatic logic [2:0] l_of_lvl(input logic [2:0] lvl);
      logic [2:0] l;
      case (lvl)
         3'd2:    l = 3'(L_LVL2);
         3'd5:    l = 3'(L_LVL5);
         default: l = 3'(L_LVL3);
      endcase
      return l;
   endfunction

endpackage

// File: rtl/y_poly_writer.sv
// Streams sampled y-vector coefficients into memory, one polynomial (64 words) at a time.
// Write latency 1 cycle; ready_i high only in WRITE, a one-cycle FLUSH separates polynomials.
module y_poly_writer #(
   parameter int SAMPLE_W = y_poly_writer_pkg::SAMPLE_W,
   parameter int BUS_W    = y_poly_writer_pkg::BUS_W,
   parameter int ADDR_W   = 9
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [2:0]                sec_lvl,
   input  logic                      start,
   input  logic [ADDR_W-1:0]         base_addr,
   input  logic                      valid_i,
   output logic                      ready_i,
   input  logic [SAMPLE_W*BUS_W-1:0] samples,
   output logic                      mem_we,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [SAMPLE_W*BUS_W-1:0] mem_wdata,
   output logic [2:0]                poly_idx,
   output logic                      flush_o,
   output logic                      poly_done,
   output logic                      done,
   output logic                      busy
);
   import y_poly_writer_pkg::*;

   localparam logic [5:0] LAST_BEAT = 6'(BEATS_PER_POLY - 1);

   state_e                    state_q, state_d;
   logic [2:0]                l_q, l_d;
   logic [ADDR_W-1:0]         base_q, base_d;
   logic [2:0]                poly_idx_q, poly_idx_d;
   logic [5:0]                beat_cnt_q, beat_cnt_d;
   logic                      mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]         mem_addr_q, mem_addr_d;
   logic [SAMPLE_W*BUS_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [ADDR_W-1:0]         addr_off;

   // {poly_idx, beat_cnt} is poly_idx*64 + beat_cnt; the add wraps modulo 2^ADDR_W.
   assign addr_off = ADDR_W'({poly_idx_q, beat_cnt_q});

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         l_q         <= '0;
         base_q      <= '0;
         poly_idx_q  <= '0;
         beat_cnt_q  <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         l_q         <= l_d;
         base_q      <= base_d;
         poly_idx_q  <= poly_idx_d;
         beat_cnt_q  <= beat_cnt_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      l_d         = l_q;
      base_d      = base_q;
      poly_idx_d  = poly_idx_q;
      beat_cnt_d  = beat_cnt_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      ready_i     = 1'b0;
      flush_o     = 1'b0;
      poly_done   = 1'b0;
      done        = 1'b0;
      busy        = (state_q != ST_IDLE);

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               l_d        = l_of_lvl(sec_lvl);
               base_d     = base_addr;
               poly_idx_d = '0;
               beat_cnt_d = '0;
               state_d    = ST_WRITE;
            end
         end
         ST_WRITE: begin
            ready_i = 1'b1;
            if (valid_i) begin
               mem_we_d    = 1'b1;
               mem_addr_d  = base_q + addr_off;
               mem_wdata_d = samples;
               beat_cnt_d  = beat_cnt_q + 6'd1;
               if (beat_cnt_q == LAST_BEAT) begin
                  state_d = ST_FLUSH;
               end
            end
         end
         ST_FLUSH: begin
            flush_o    = 1'b1;
            poly_done  = 1'b1;
            beat_cnt_d = '0;
            // The final index is kept visible after the vector completes.
            if (poly_idx_q == 3'(l_q - 3'd1)) begin
               state_d = ST_DONE;
            end else begin
               poly_idx_d = poly_idx_q + 3'd1;
               state_d    = ST_WRITE;
            end
         end
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign poly_idx  = poly_idx_q;

endmodule

// File: tb/tb_y_poly_writer.sv
// Random-stimulus bench: a stimulus process predicts each memory write from the vector rules
// (address = base + running beat index) and a monitor pops and compares as the DUT writes.
module tb_y_poly_writer;
   localparam int SW = 23;
   localparam int BW = 4;
   localparam int AW = 9;
   localparam int DW = SW * BW;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      bit            last_in_poly;
      bit            last_in_run;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [2:0]    sec_lvl = '0;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic          valid_i = 1'b0;
   logic          ready_i;
   logic [DW-1:0] samples = '0;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [2:0]    poly_idx;
   logic          flush_o, poly_done, done, busy;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   pend_done = 0;

   always #5 clk = ~clk;

   y_poly_writer #(.SAMPLE_W(SW), .BUS_W(BW), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .sec_lvl(sec_lvl), .start(start), .base_addr(base_addr),
      .valid_i(valid_i), .ready_i(ready_i), .samples(samples), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .poly_idx(poly_idx), .flush_o(flush_o),
      .poly_done(poly_done), .done(done), .busy(busy)
   );

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, got, want);
      end
   endtask

   function automatic int ref_l(input logic [2:0] lvl);
      if (lvl == 3'd2) return 4;
      if (lvl == 3'd5) return 7;
      return 5;
   endfunction

   // Monitor: every DUT write must match the oldest predicted write.
   initial begin : monitor
      exp_t e;
      bit   exp_pd;
      bit   nxt_done;
      forever begin
         @(negedge clk);
         exp_pd   = 1'b0;
         nxt_done = 1'b0;
         if (mem_we) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_write: addr %0h with no write predicted", mem_addr);
            end else begin
               e = exp_q.pop_front();
               chk("mem_addr", 128'(mem_addr), 128'(e.addr));
               chk("mem_wdata", 128'(mem_wdata), 128'(e.data));
               exp_pd   = e.last_in_poly;
               nxt_done = e.last_in_run;
            end
         end
         if (poly_done || exp_pd) chk("poly_done", 128'(poly_done), 128'(exp_pd));
         if (flush_o || exp_pd)   chk("flush_o", 128'(flush_o), 128'(exp_pd));
         if (flush_o)             chk("ready_in_flush", 128'(ready_i), 128'(0));
         if (done || pend_done)   chk("done", 128'(done), 128'(pend_done));
         pend_done = nxt_done;
      end
   end

   task automatic run_vec(input logic [2:0] lvl, input logic [AW-1:0] base, input int gap,
                          input int abort_after, input bit poke);
      int            l;
      int            k;
      int            cyc;
      int            w;
      int unsigned   r;
      logic [DW-1:0] s;
      exp_t          e;
      l = ref_l(lvl);
      @(negedge clk);
      sec_lvl   = lvl;
      base_addr = base;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k   = 0;
      cyc = 0;
      while (k < l * 64 && cyc < 4000) begin
         if (abort_after >= 0 && k == abort_after) break;
         valid_i = ($urandom_range(99) >= gap);
         r = $urandom; s[31:0]  = r;
         r = $urandom; s[63:32] = r;
         r = $urandom; s[DW-1:64] = r[DW-65:0];
         samples = s;
         if (poke && k >= 70 && k < 74) begin
            start   = 1'b1;
            sec_lvl = 3'd5;
         end else begin
            start = 1'b0;
         end
         #1;
         if (valid_i && ready_i) begin
            e.addr         = AW'(int'(base) + k);
            e.data         = s;
            e.last_in_poly = (k % 64 == 63);
            e.last_in_run  = (k == l * 64 - 1);
            exp_q.push_back(e);
            k++;
         end
         @(negedge clk);
         cyc++;
      end
      valid_i = 1'b0;
      start   = 1'b0;
      if (cyc >= 4000) begin
         n_checks++;
         n_fail++;
         $display("FAIL beat_budget: accepted %0d beats, required %0d", k, l * 64);
      end
      if (abort_after >= 0) begin
         rst     = 1'b1;
         valid_i = 1'b1;
         start   = 1'b1;
         @(negedge clk);
         rst     = 1'b0;
         valid_i = 1'b0;
         start   = 1'b0;
         #1;
         chk("rst_mem_we", 128'(mem_we), 128'(0));
         chk("rst_mem_addr", 128'(mem_addr), 128'(0));
         chk("rst_mem_wdata", 128'(mem_wdata), 128'(0));
         chk("rst_ready", 128'(ready_i), 128'(0));
         chk("rst_busy", 128'(busy), 128'(0));
         chk("rst_poly_idx", 128'(poly_idx), 128'(0));
         chk("rst_pulses", 128'({flush_o, poly_done, done}), 128'(0));
         repeat (3) @(negedge clk);
         #1;
         chk("rst_no_done", 128'(done), 128'(0));
      end else begin
         #1;
         w = 0;
         while (!done && w < 12) begin
            @(negedge clk);
            #1;
            w++;
         end
         chk("done_seen", 128'(done), 128'(1));
         chk("final_poly_idx", 128'(poly_idx), 128'(l - 1));
         @(negedge clk);
         #1;
         chk("idle_busy", 128'(busy), 128'(0));
         chk("held_poly_idx", 128'(poly_idx), 128'(l - 1));
      end
      chk("queue_drained", 128'(exp_q.size()), 128'(0));
   endtask

   initial begin : stimulus
      repeat (3) @(negedge clk);
      #1;
      chk("reset_ready", 128'(ready_i), 128'(0));
      chk("reset_busy", 128'(busy), 128'(0));
      chk("reset_mem_we", 128'(mem_we), 128'(0));
      chk("reset_poly_idx", 128'(poly_idx), 128'(0));
      rst = 1'b0;
      run_vec(3'd2, 9'h000, 0, -1, 1'b0);
      run_vec(3'd5, 9'h1C0, 0, -1, 1'b0);
      run_vec(3'd3, 9'($urandom_range(511)), 50, -1, 1'b0);
      run_vec(3'd3, 9'h020, 0, 100, 1'b0);
      run_vec(3'd2, 9'h055, 0, -1, 1'b0);
      run_vec(3'd2, 9'h100, 30, -1, 1'b1);
      run_vec(3'd7, 9'h010, 25, -1, 1'b0);
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
